packet_forwarder: RTL and testbench

- Reader for the forwarder side of packet memory.
- When packet memory reports a filtered packet ready, it reads the packet out as 64-bit words and emits it on an AXI-Stream master with TKEEP/TLAST. When the last beat is accepted, it issues a 1-cycle forwarder_done pulse to release the buffer.
- Sits between packet memory's forwarder port and the downstream egress stream.

---
 rtl/packet_forwarder.sv | 155 +++++++++++++++
 tb/tb_packet_forwarder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_forwarder.sv
// packet_forwarder: drains one buffered packet from packet memory as 64-bit
// AXI-Stream beats and releases the buffer with a one-cycle done pulse.
module packet_forwarder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready_for_forwarder,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                  forwarder_rd_en,
    input  logic [63:0]           forwarder_rd_data,
    output logic                  forwarder_done,
    output logic [63:0]           m_tdata,
    output logic [7:0]            m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [31:0]           pkt_count
);
    localparam int DATA_W = 64;
    localparam int WORD_W = ADDR_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(8) << ADDR_WIDTH;

    // Lengths beyond the buffer size are clamped to a full buffer.
    function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    function automatic logic [7:0] tail_keep(input logic [2:0] rem);
        return (rem == 3'd0) ? 8'hFF : 8'((9'd1 << rem) - 9'd1);
    endfunction

    typedef enum logic [1:0] {IDLE, STREAM, DONE, COOL} state_t;

    state_t                  state, state_nxt;
    logic [WORD_W-1:0]       words_q;
    logic [WORD_W-1:0]       issued_q;
    logic [7:0]              lastkeep_q;
    logic [ADDR_WIDTH-1:0]   addr_hold_q;
    logic [LEN_WIDTH-1:0]    len_sat;
    logic [LEN_WIDTH-1:0]    len_rnd;
    logic [WORD_W-1:0]       words_d;
    logic                    issue;
    logic                    pop;
    logic                    credit_ok;
    logic [2:0]              occupancy;

    logic                    vld_p1;
    logic                    last_p1;

    logic [DATA_W-1:0]       fifo_data [2];
    logic [1:0]              fifo_last;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              fifo_cnt;

    assign len_sat = sat_len(pkt_len);
    assign len_rnd = len_sat + LEN_WIDTH'(7);
    assign words_d = WORD_W'(len_rnd >> 3);

    assign pop       = m_tvalid & m_tready;
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, vld_p1};
    // A word leaving this cycle frees a slot for a read issued this cycle.
    assign credit_ok = occupancy < (3'd2 + {2'b00, pop});

    always_comb begin
        state_nxt      = state;
        issue          = 1'b0;
        forwarder_done = 1'b0;
        case (state)
            IDLE: begin
                if (ready_for_forwarder) begin
                    state_nxt = (pkt_len != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                issue = (issued_q < words_q) && credit_ok;
                if (pop && m_tlast) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                forwarder_done = 1'b1;
                state_nxt      = COOL;
            end
            COOL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            issue          = 1'b0;
            forwarder_done = 1'b0;
        end
    end

    assign forwarder_rd_en   = issue;
    assign forwarder_rd_addr = issue ? issued_q[ADDR_WIDTH-1:0] : addr_hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            words_q     <= '0;
            issued_q    <= '0;
            lastkeep_q  <= '0;
            addr_hold_q <= '0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            fifo_last   <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= '0;
            pkt_count   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && ready_for_forwarder) begin
                words_q    <= words_d;
                lastkeep_q <= tail_keep(len_sat[2:0]);
                issued_q   <= '0;
            end else if (issue) begin
                issued_q <= issued_q + WORD_W'(1);
            end
            if (issue) begin
                addr_hold_q <= issued_q[ADDR_WIDTH-1:0];
            end
            // Stage p1: read data returns one cycle after the strobe.
            vld_p1  <= issue;
            last_p1 <= issue && (issued_q == words_q - WORD_W'(1));
            if (vld_p1) begin
                fifo_last[wr_ptr] <= last_p1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, vld_p1} - {1'b0, pop};
            if (state == DONE) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            fifo_data[wr_ptr] <= forwarder_rd_data;
        end
    end

    // Stage p2: FIFO head presented on the stream; idle outputs read as zero.
    assign m_tvalid = (fifo_cnt != 2'd0);
    assign m_tdata  = m_tvalid ? fifo_data[rd_ptr] : '0;
    assign m_tlast  = m_tvalid & fifo_last[rd_ptr];
    assign m_tkeep  = !m_tvalid ? 8'h00 : (fifo_last[rd_ptr] ? lastkeep_q : 8'hFF);

endmodule

// File: tb/tb_packet_forwarder.sv
// Scoreboard bench for packet_forwarder: a byte-level packet model predicts
// every stream beat, done pulse and packet count; a monitor checks them.
module tb_packet_forwarder;
    localparam int AW    = 5;
    localparam int LW    = AW + 4;
    localparam int DEPTH = 1 << AW;
    localparam int MAXB  = 8 * DEPTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic [LW-1:0] pkt_len;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [63:0]   rd_data;
    logic          done;
    logic [63:0]   tdata;
    logic [7:0]    tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic [31:0]   pkt_count;

    always #5 clk = ~clk;

    packet_forwarder #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ready_for_forwarder (ready),
        .pkt_len             (pkt_len),
        .forwarder_rd_addr   (rd_addr),
        .forwarder_rd_en     (rd_en),
        .forwarder_rd_data   (rd_data),
        .forwarder_done      (done),
        .m_tdata             (tdata),
        .m_tkeep             (tkeep),
        .m_tlast             (tlast),
        .m_tvalid            (tvalid),
        .m_tready            (tready),
        .pkt_count           (pkt_count)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t       beat_q[$];
    int unsigned done_q[$];
    logic [63:0] mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tready_mode = 0;
    int cur_words = 0, rd_in_pkt = 0, hs_in_pkt = 0;
    int first_rd_cyc = -1, first_vld_cyc = -1, done_cyc = -1, done_seen = 0;
    int rd_total = 0, hs_total = 0;
    int unsigned exp_count = 0;
    int start_cyc, done_base;

    logic        pend_cnt = 1'b0;
    int unsigned pend_val;
    logic        stall_prev = 1'b0;
    beat_t       held;
    beat_t       exp_b;
    int          pop_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Packet memory read port: registered, one cycle of latency, junk otherwise.
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : {$urandom, $urandom};
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (tready_mode)
                0: tready = 1'b1;
                1: tready = ~tready;
                2: tready = ($urandom_range(0, 3) != 0);
                default: tready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            pend_cnt   = 1'b0;
            rd_total   = 0;
            hs_total   = 0;
        end else begin
            pop_i = (tvalid && tready) ? 1 : 0;
            if (pend_cnt) begin
                check("pkt_count", pkt_count, pend_val);
                pend_cnt = 1'b0;
            end
            if (stall_prev) begin
                check("hold_valid", tvalid, 1'b1);
                check("hold_data", tdata, held.data);
                check("hold_ctl", {tkeep, tlast}, {held.keep, held.last});
            end
            if (rd_en) begin
                check("rd_addr_order", rd_addr, rd_in_pkt);
                check("rd_in_range", rd_in_pkt < cur_words, 1'b1);
                check("rd_outstanding", (rd_total + 1 - hs_total - pop_i) <= 2, 1'b1);
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                rd_in_pkt++;
                rd_total++;
            end
            if (tvalid) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (tready) begin
                    check("beat_expected", beat_q.size() != 0, 1'b1);
                    if (beat_q.size() != 0) begin
                        exp_b = beat_q.pop_front();
                        check("tdata", tdata, exp_b.data);
                        check("tkeep_tlast", {tkeep, tlast}, {exp_b.keep, exp_b.last});
                    end
                    hs_in_pkt++;
                    hs_total++;
                end
            end
            stall_prev = tvalid && !tready;
            held = '{data: tdata, keep: tkeep, last: tlast};
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                check("done_expected", done_q.size() != 0, 1'b1);
                if (done_q.size() != 0) begin
                    check("done_after_last_beat", beat_q.size(), 0);
                    pend_val = done_q.pop_front();
                    pend_cnt = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte b of the packet lives in word b/8, lane b%8.
    task automatic load_pkt(input int len);
        int lc, nb;
        for (int a = 0; a < DEPTH; a++) mem[a] = {$urandom, $urandom};
        lc = (len > MAXB) ? MAXB : len;
        nb = (lc + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            beat_t b;
            b.data = mem[k];
            for (int i = 0; i < 8; i++) b.keep[i] = ((8 * k + i) < lc);
            b.last = (k == nb - 1);
            beat_q.push_back(b);
        end
        exp_count++;
        done_q.push_back(exp_count);
        cur_words     = nb;
        rd_in_pkt     = 0;
        hs_in_pkt     = 0;
        first_rd_cyc  = -1;
        first_vld_cyc = -1;
        done_base     = done_seen;
        pkt_len       = LW'(len);
    endtask

    task automatic send(input int len);
        load_pkt(len);
        ready     = 1'b1;
        start_cyc = cyc;
        tick();
        ready = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_seen == done_base && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", done_seen > done_base, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tvalid"}, tvalid, 1'b0);
        check({tag, "_tdata"}, tdata, 64'd0);
        check({tag, "_tkeep_tlast"}, {tkeep, tlast}, 9'd0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_rd"}, {rd_en, rd_addr}, '0);
        check({tag, "_pkt_count"}, pkt_count, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1;
        rst = 1'b1;
        ready = 1'b0;
        pkt_len = '0;
        repeat (3) tick();
        @(negedge clk);
        check_zero_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // 20 bytes, no backpressure: latency and tail keep
        tready_mode = 0;
        send(20);
        wait_done(200);
        check("t1_first_rd", first_rd_cyc - start_cyc, 1);
        check("t1_first_vld", first_vld_cyc - start_cyc, 3);
        check("t1_done", done_cyc - start_cyc, 6);
        check("t1_reads", rd_in_pkt, 3);

        // 16 bytes with alternating ready
        tick();
        tready_mode = 1;
        send(16);
        wait_done(200);
        check("t2_reads", rd_in_pkt, 2);
        check("t2_beats", hs_in_pkt, 2);

        // zero-length packet
        tick();
        tready_mode = 0;
        send(0);
        wait_done(50);
        check("t3_done", done_cyc - start_cyc, 1);
        check("t3_no_rd", first_rd_cyc < 0, 1'b1);
        check("t3_no_vld", first_vld_cyc < 0, 1'b1);

        // 1 byte then 64 bytes with ready held high
        tick();
        load_pkt(1);
        ready = 1'b1;
        tick();
        wait_done(200);
        d1 = done_cyc;
        check("t4a_beats", hs_in_pkt, 1);
        load_pkt(64);
        tick();
        tick();
        ready = 1'b0;
        wait_done(200);
        check("t4_cool_gap", first_rd_cyc - d1, 3);
        check("t4b_beats", hs_in_pkt, 8);

        // 40 bytes stalled after first valid
        tick();
        tready_mode = 3;
        send(40);
        repeat (12) tick();
        check("t5_reads_stalled", rd_in_pkt, 2);
        check("t5_beats_stalled", hs_in_pkt, 0);
        check("t5_first_vld", first_vld_cyc - start_cyc, 3);
        tready_mode = 0;
        wait_done(200);
        check("t5_beats", hs_in_pkt, 5);

        // reset during beat 2 of 5
        tick();
        send(40);
        for (int n = 0; n < 50 && hs_in_pkt < 1; n++) tick();
        check("t6_beat1_seen", hs_in_pkt, 1);
        rst = 1'b1;
        beat_q.delete();
        done_q.delete();
        exp_count = 0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("midreset");
        repeat (5) tick();
        send(24);
        wait_done(200);
        check("t6_fresh_reads", rd_in_pkt, 3);

        // randomized lengths (including clamp) with random backpressure
        tready_mode = 2;
        for (int p = 0; p < 20; p++) begin
            tick();
            send((p % 5 == 0) ? $urandom_range(MAXB - 8, MAXB + 60) : $urandom_range(0, 90));
            wait_done(3000);
        end

        tready_mode = 0;
        repeat (4) tick();
        check("final_beats_left", beat_q.size(), 0);
        check("final_done_left", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
